// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the 4x4 RAM sequencing controller.
package ram_ctrl_pkg;
  localparam int WORDS  = 4;
  localparam int WIDTH  = 4;
  localparam int ADDR_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_WRITE, ST_READ, ST_VERIFY, ST_DONE
  } state_e;

  function automatic logic [WORDS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [WORDS-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/addr_dec2x4.sv
// 2-to-4 one-hot word-select decoder; all-zero when disabled.
module addr_dec2x4
  import ram_ctrl_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORDS-1:0]  sel
);
  assign sel = en ? onehot(addr) : '0;
endmodule

// File: rtl/ram_ctrl4x4.sv
// Req/ack sequencer for a 4x4 bank of gated-clock 1x4 RAM cells.
// Optional write read-back check enabled by RAM_CTRL4X4_VERIFY_EN.
module ram_ctrl4x4
  import ram_ctrl_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              ack,
  output logic              busy,
  output logic              err,
  output logic              ram_rw,
  output logic [WORDS-1:0]  ram_sel,
  output logic [WIDTH-1:0]  ram_din,
  input  logic [WIDTH-1:0]  ram_dout
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rdata_q, rdata_d, ram_din_q, ram_din_d;
  logic [WORDS-1:0] ram_sel_q, ram_sel_d, dec_sel;
  logic             ack_q, ack_d, busy_q, busy_d, ram_rw_q, ram_rw_d, we_q, we_d;
`ifdef RAM_CTRL4X4_VERIFY_EN
  logic             err_q, err_d;
`endif

  addr_dec2x4 u_dec (.en(req), .addr(addr), .sel(dec_sel));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      rdata_q   <= '0;
      ram_din_q <= '0;
      ram_sel_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      ram_rw_q  <= 1'b0;
      we_q      <= 1'b0;
`ifdef RAM_CTRL4X4_VERIFY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      ram_din_q <= ram_din_d;
      ram_sel_q <= ram_sel_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      ram_rw_q  <= ram_rw_d;
      we_q      <= we_d;
`ifdef RAM_CTRL4X4_VERIFY_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req) state_d = ST_SETUP;
      ST_SETUP:  state_d = we_q ? ST_WRITE : ST_READ;
`ifdef RAM_CTRL4X4_VERIFY_EN
      ST_WRITE:  state_d = ST_VERIFY;
      ST_VERIFY: state_d = ST_DONE;
`else
      ST_WRITE:  state_d = ST_DONE;
`endif
      ST_READ:   state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so each is computed from the transition being taken.
  always_comb begin
    rdata_d   = rdata_q;
    ram_din_d = ram_din_q;
    ram_sel_d = ram_sel_q;
    ram_rw_d  = ram_rw_q;
    we_d      = we_q;
    ack_d     = (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE);
`ifdef RAM_CTRL4X4_VERIFY_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: if (req) begin
        we_d      = we;
        ram_sel_d = dec_sel;
        ram_din_d = wdata;
        ram_rw_d  = 1'b0;
      end
      ST_SETUP: ram_rw_d = we_q;
      ST_WRITE: ram_rw_d = 1'b0;
      ST_READ:  rdata_d  = ram_dout;
`ifdef RAM_CTRL4X4_VERIFY_EN
      ST_VERIFY: begin
        rdata_d = ram_dout;
        err_d   = (ram_dout != ram_din_q);
      end
`endif
      ST_DONE:  ram_sel_d = '0;
      default:  ;
    endcase
  end

  assign rdata   = rdata_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign ram_rw  = ram_rw_q;
  assign ram_sel = ram_sel_q;
  assign ram_din = ram_din_q;
`ifdef RAM_CTRL4X4_VERIFY_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_ram_ctrl4x4.sv
// Directed bench for ram_ctrl4x4 with a behavioural 4x4 cell-bank model.
module tb_ram_ctrl4x4;
  logic       clk = 1'b0, clr = 1'b0, req = 1'b0, we = 1'b0;
  logic [1:0] addr = '0;
  logic [3:0] wdata = '0, rdata, ram_din, ram_dout, ram_sel;
  logic       ack, busy, err, ram_rw;
  logic [3:0] mem [4];
  int         n_chk = 0, n_fail = 0;

  ram_ctrl4x4 dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err), .ram_rw(ram_rw),
    .ram_sel(ram_sel), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Cells capture on the rising edge of rw (their gated clock); cell 2 bit 2 stuck low when verifying.
  always @(posedge ram_rw or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) mem[i] = 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++)
        if (ram_sel[i]) begin
`ifdef RAM_CTRL4X4_VERIFY_EN
          mem[i] = (i == 2) ? (ram_din & 4'b1011) : ram_din;
`else
          mem[i] = ram_din;
`endif
        end
    end
  end

  always_comb begin
    ram_dout = 4'b0000;
    for (int i = 0; i < 4; i++) if (ram_sel[i]) ram_dout = mem[i];
  end

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_rd;
    logic       exp_err;
  } vec_t;

`ifdef RAM_CTRL4X4_VERIFY_EN
  localparam bit VER = 1'b1;
  localparam int NV  = 6;
`else
  localparam bit VER = 1'b0;
  localparam int NV  = 7;
`endif
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic op(input logic w, input logic [1:0] a, input logic [3:0] d,
                    input logic [3:0] exp_rd, input logic exp_err);
    logic [3:0] oh;
    oh = 4'b0001 << a;
    @(negedge clk); req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1 req = 1'b0;                        // E0
    chk("e0_sel", ram_sel, oh); chk("e0_din", ram_din, d);
    chk("e0_rw", {3'b0, ram_rw}, 4'd0); chk("e0_busy", {3'b0, busy}, 4'd1);
    chk("e0_ack", {3'b0, ack}, 4'd0);
    @(posedge clk); #1;                                   // E1
    chk("e1_rw", {3'b0, ram_rw}, {3'b0, w}); chk("e1_ack", {3'b0, ack}, 4'd0);
    chk("e1_sel", ram_sel, oh);
    @(posedge clk); #1;                                   // E2
    chk("e2_rw", {3'b0, ram_rw}, 4'd0); chk("e2_sel", ram_sel, oh);
    if (w && VER) begin
      chk("e2_ack_ver", {3'b0, ack}, 4'd0);
      @(posedge clk); #1;                                 // E3
      chk("e3_ack_ver", {3'b0, ack}, 4'd1); chk("e3_sel_ver", ram_sel, oh);
      chk("e3_rw_ver", {3'b0, ram_rw}, 4'd0);
    end else begin
      chk("e2_ack", {3'b0, ack}, 4'd1);
    end
    chk("rdata", rdata, exp_rd); chk("err", {3'b0, err}, {3'b0, exp_err});
    @(posedge clk); #1;
    chk("end_ack", {3'b0, ack}, 4'd0); chk("end_busy", {3'b0, busy}, 4'd0);
    chk("end_sel", ram_sel, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RAM_CTRL4X4_VERIFY_EN
    tbl[0] = '{1'b1, 2'd2, 4'b1101, 4'b1001, 1'b1};
    tbl[1] = '{1'b0, 2'd2, 4'b0000, 4'b1001, 1'b1};
    tbl[2] = '{1'b1, 2'd0, 4'b0110, 4'b0110, 1'b0};
    tbl[3] = '{1'b1, 2'd3, 4'b1010, 4'b1010, 1'b0};
    tbl[4] = '{1'b0, 2'd3, 4'b0000, 4'b1010, 1'b0};
    tbl[5] = '{1'b0, 2'd2, 4'b0000, 4'b1001, 1'b0};
`else
    tbl[0] = '{1'b1, 2'd2, 4'b1101, 4'b0000, 1'b0};
    tbl[1] = '{1'b0, 2'd2, 4'b0000, 4'b1101, 1'b0};
    tbl[2] = '{1'b1, 2'd0, 4'b0110, 4'b1101, 1'b0};
    tbl[3] = '{1'b1, 2'd3, 4'b1111, 4'b1101, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 4'b0000, 4'b0110, 1'b0};
    tbl[5] = '{1'b0, 2'd3, 4'b0000, 4'b1111, 1'b0};
    tbl[6] = '{1'b0, 2'd1, 4'b0000, 4'b0000, 1'b0};
`endif
    // Async reset before any clock edge.
    #2 clr = 1'b1;
    #1;
    chk("rst_rdata", rdata, 4'd0); chk("rst_sel", ram_sel, 4'd0);
    chk("rst_din", ram_din, 4'd0); chk("rst_ctl", {ack, busy, err, ram_rw}, 4'd0);
    @(negedge clk); clr = 1'b0;

    for (int i = 0; i < NV; i++)
      op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);

    // Request during an active read is dropped, not queued.
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 2'd2;
    @(posedge clk); #1 req = 1'b0;                        // E0
    #2 req = 1'b1; we = 1'b1; addr = 2'd0; wdata = 4'b1111;
    @(posedge clk); #1 req = 1'b0;                        // E1
    chk("bz_e1_rw", {3'b0, ram_rw}, 4'd0); chk("bz_e1_sel", ram_sel, 4'b0100);
    @(posedge clk); #1;                                   // E2
    chk("bz_e2_ack", {3'b0, ack}, 4'd1);
    chk("bz_rdata", rdata, VER ? 4'b1001 : 4'b1101);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bz_no_ack", {3'b0, ack}, 4'd0); chk("bz_idle", {ram_rw, busy, 2'b0}, 4'd0);
      chk("bz_sel", ram_sel, 4'd0);
    end
    op(1'b0, 2'd0, 4'b0000, 4'b0110, 1'b0);               // cell 0 unchanged

    // Abort a write while rw is high.
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 2'd1; wdata = 4'b1111;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1;
    chk("ab_rw_hi", {3'b0, ram_rw}, 4'd1);
    #2 clr = 1'b1;
    #1;
    chk("ab_rw", {3'b0, ram_rw}, 4'd0); chk("ab_sel", ram_sel, 4'd0);
    chk("ab_ctl", {ack, busy, err, 1'b0}, 4'd0); chk("ab_rdata", rdata, 4'd0);
    @(negedge clk); clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("ab_no_ack", {3'b0, ack}, 4'd0); chk("ab_busy", {3'b0, busy}, 4'd0);
    end
    op(1'b1, 2'd1, 4'b0011, VER ? 4'b0011 : 4'b0000, 1'b0);
    op(1'b0, 2'd1, 4'b0000, 4'b0011, 1'b0);
    op(1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0);               // bank cleared by clr

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
